// File: rtl/full_adder_32b_pkg.sv
// Shared types and constants for the registered add/subtract datapath.
package full_adder_32b_pkg;

    // Width of one carry-lookahead slice.
    localparam int unsigned CLA_W = 4;

    // Operation selected by the adder carry-in pin.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/full_adder_32b_cla.sv
// 4-bit carry-lookahead slice with group propagate/generate outputs.
module cla_4b
    import full_adder_32b_pkg::*;
(
    input  logic [CLA_W-1:0] a,
    input  logic [CLA_W-1:0] b,
    input  logic             ci,
    output logic [CLA_W-1:0] s,
    output logic             co,
    output logic             pg,
    output logic             gg
);

    logic [CLA_W-1:0] p;
    logic [CLA_W-1:0] g;
    logic [CLA_W:0]   c;

    // Per-bit propagate/generate, flattened lookahead carries, sum and group terms.
    always_comb begin
        p = a ^ b;
        g = a & b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
        pg   = &p;
        c[4] = gg | (pg & ci);
        s    = p ^ c[CLA_W-1:0];
        co   = c[4];
    end

endmodule

// File: rtl/full_adder_32b.sv
// Registered WIDTH-bit add/subtract unit: cin=0 adds, cin=1 subtracts
// (a + ~b + 1). cout is carry-out when adding and borrow-out when subtracting.
module full_adder_32b
    import full_adder_32b_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NSLICE = WIDTH / CLA_W;

    op_e              op;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum_next;
    logic [NSLICE:0]  carry;
    logic [NSLICE-1:0] slice_pg;
    logic [NSLICE-1:0] slice_gg;
    logic [NSLICE-1:0] unused_slice_co;
    logic             cout_next;

    assign op = op_e'(cin);

    // Conditional inversion of operand B; cin doubles as the +1 for subtract.
    always_comb begin
        b_eff = b ^ {WIDTH{op == OP_SUB}};
    end

    // Second-level chain: slice carries are derived from group P/G, so the
    // per-slice carry-out ports are redundant and left unused.
    always_comb begin
        carry = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            carry[i+1] = slice_gg[i] | (slice_pg[i] & carry[i]);
        end
    end

    for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
        cla_4b u_cla (
            .a  (a[gi*CLA_W +: CLA_W]),
            .b  (b_eff[gi*CLA_W +: CLA_W]),
            .ci (carry[gi]),
            .s  (sum_next[gi*CLA_W +: CLA_W]),
            .co (unused_slice_co[gi]),
            .pg (slice_pg[gi]),
            .gg (slice_gg[gi])
        );
    end

    // Subtract reports borrow, which is the inverted internal carry.
    always_comb begin
        cout_next = carry[NSLICE] ^ (op == OP_SUB);
    end

    // Output registers with synchronous reset taking priority over operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_next;
            cout <= cout_next;
        end
    end

endmodule

// File: tb/tb_full_adder_32b.sv
// Directed and random checks for the registered 32-bit add/subtract unit.
module tb_full_adder_32b;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;

    int n_checks;
    int n_fail;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    vec_t vecs[10];

    full_adder_32b #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] exp_sum, input logic exp_cout);
        n_checks++;
        if (sum !== exp_sum || cout !== exp_cout) begin
            n_fail++;
            $display("FAIL %s: got sum=%h cout=%b, expected sum=%h cout=%b",
                     name, sum, cout, exp_sum, exp_cout);
        end
    endtask

    // Reference model written independently of the RTL structure.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mc,
                         output logic [31:0] ms, output logic mco);
        logic [32:0] wide;
        if (mc == 1'b0) begin
            wide = {1'b0, ma} + {1'b0, mb};
            ms   = wide[31:0];
            mco  = wide[32];
        end else begin
            ms  = ma - mb;
            mco = (ma < mb);
        end
    endtask

    initial begin
        logic [31:0] pa[8];
        logic [31:0] pb[8];
        logic        pc[8];
        logic [31:0] exp_s;
        logic        exp_c;
        logic        prev_rst;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{"add_1_2",      32'h00000001, 32'h00000002, 1'b0, 32'h00000003, 1'b0};
        vecs[1] = '{"add_x_0",      32'h12345678, 32'h00000000, 1'b0, 32'h12345678, 1'b0};
        vecs[2] = '{"sub_f_1",      32'h0000000F, 32'h00000001, 1'b1, 32'h0000000E, 1'b0};
        vecs[3] = '{"sub_1_2",      32'h00000001, 32'h00000002, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{"sub_eq",       32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b0};
        vecs[5] = '{"wrap_max_1",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[6] = '{"wrap_msb",     32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[7] = '{"wrap_fff0",    32'hFFFFFFF0, 32'hFFFFFFF0, 1'b0, 32'hFFFFFFE0, 1'b1};
        vecs[8] = '{"wrap_10_fff0", 32'h00000010, 32'hFFFFFFF0, 1'b0, 32'h00000000, 1'b1};
        vecs[9] = '{"wrap_5_ffff",  32'h00000005, 32'hFFFFFFFF, 1'b0, 32'h00000004, 1'b1};

        // Reset held two cycles with live operands.
        rst = 1'b1; a = 32'h12345678; b = 32'h00000001; cin = 1'b0;
        @(posedge clk); #1;
        check("reset_cycle1", 32'h0, 1'b0);
        @(posedge clk); #1;
        check("reset_cycle2", 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("after_reset", 32'h12345679, 1'b0);

        // Directed table, each checked one cycle after apply.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin;
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // Back-to-back operands with a reset pulse in cycle 4.
        pa[0] = 32'h00000010; pb[0] = 32'h00000020; pc[0] = 1'b0;  // 0x30, 0
        pa[1] = 32'h00000010; pb[1] = 32'h00000020; pc[1] = 1'b1;  // 0xFFFFFFF0, 1
        pa[2] = 32'hFFFF0000; pb[2] = 32'h00010000; pc[2] = 1'b0;  // 0, 1
        pa[3] = 32'hAAAAAAAA; pb[3] = 32'h55555555; pc[3] = 1'b1;  // 0x55555555, 0
        pa[4] = 32'h11111111; pb[4] = 32'h11111111; pc[4] = 1'b0;  // discarded by reset
        pa[5] = 32'h7FFFFFFF; pb[5] = 32'h00000001; pc[5] = 1'b0;  // 0x80000000, 0
        pa[6] = 32'h00000000; pb[6] = 32'h00000001; pc[6] = 1'b1;  // 0xFFFFFFFF, 1
        pa[7] = 32'h12345678; pb[7] = 32'h12345678; pc[7] = 1'b1;  // 0, 0
        prev_rst = 1'b0;
        exp_s = '0; exp_c = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                if (prev_rst) check("pipe_reset", 32'h0, 1'b0);
                else          check($sformatf("pipe_%0d", i - 1), exp_s, exp_c);
            end
            if (i < 8) begin
                a = pa[i]; b = pb[i]; cin = pc[i];
                rst = (i == 4);
                prev_rst = rst;
                model(pa[i], pb[i], pc[i], exp_s, exp_c);
            end else begin
                rst = 1'b0;
            end
        end

        // Hand-computed spot check of the model on one pipeline entry.
        model(32'hAAAAAAAA, 32'h55555555, 1'b1, exp_s, exp_c);
        a = 32'hAAAAAAAA; b = 32'h55555555; cin = 1'b1;
        @(posedge clk); #1;
        check("sub_aaaa_5555", 32'h55555555, 1'b0);

        // Random vectors against the 33-bit reference model.
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            if (i % 16 == 0) rb = ra;
            a = ra; b = rb; cin = rc;
            model(ra, rb, rc, exp_s, exp_c);
            @(posedge clk); #1;
            check("random", exp_s, exp_c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/full_adder_32b.md
Name: full_adder_32b

Overview:
- Registered 32-bit add/subtract unit used as the datapath adder in the CORDIC processor.
- cin selects the operation:
  - cin=0: a+b with carry-out.
  - cin=1: a−b with borrow-out.
- Result and flag are captured on the rising clock edge, giving a fixed one-cycle latency.

Parameters:
- WIDTH, 32, operand/result width in bits; all rules below are written for WIDTH=32.

Ports:
- clk   input   1      single clock; all state updates on the rising edge.
- rst   input   1      synchronous, active-high reset.
- a     input   32     operand A, unsigned or two's complement (bit-identical result).
- b     input   32     operand B.
- cin   input   1      operation select: 0 = add, 1 = subtract.
- sum   output  32     registered result.
- cout  output  1      registered flag: carry-out when adding, borrow-out when subtracting.

Behaviour:
- Reset:
  - When rst=1 at a rising edge, sum ← 0 and cout ← 0.
  - rst has priority over new operands.
  - Reset mid-stream discards the in-flight result.
- Latency:
  - Operands sampled at rising edge N appear on sum/cout after edge N, stable until edge N+1.
  - New operands are accepted every cycle (throughput 1/cycle).
  - No handshake and no valid signal.
- Add (cin=0):
  - Form the 33-bit value a + b.
  - sum = low 32 bits; cout = bit 32.
- Subtract (cin=1):
  - Internally compute a + ~b + 1.
  - sum = (a − b) mod 2^32.
  - cout = borrow = 1 iff a < b (unsigned), i.e. the inverted internal carry.
- Wrap-around:
  - 0xFFFFFFFF + 1 gives sum 0x00000000, cout 1.
  - 0 − 1 gives sum 0xFFFFFFFF, cout 1.
- Equal operands in subtract mode: sum 0, cout 0.
- No overflow flag and no saturation; the result always wraps modulo 2^32.
- The combinational path from a/b/cin to the output register inputs must meet one clock period.
- Outputs are never X after the first reset edge.

Decomposition:
- No shared package is needed.
- Sub-module cla_4b: 4-bit carry-lookahead slice.
  - Inputs: a[3:0], b[3:0], ci.
  - Outputs: s[3:0], co, group propagate, group generate.
- full_adder_32b contains:
  - eight cla_4b slices chained through a second-level lookahead (or ripple between slices);
  - the operand-B conditional inverter (b XOR {32{cin}}) with carry-in = cin;
  - the output inversion of the final carry in subtract mode;
  - the sum/cout registers with synchronous reset.

Test Plan:
- Reset: assert rst for 2 cycles with a=0x12345678, b=0x1, cin=0 → sum=0x00000000, cout=0. Deassert; after one edge → sum=0x12345679, cout=0.
- Basic add, each checked one cycle after apply:
  - 0x00000001 + 0x00000002 → sum 0x00000003, cout 0.
  - 0x12345678 + 0x00000000 → sum 0x12345678, cout 0.
- Subtract:
  - 0x0000000F − 0x00000001 (cin=1) → sum 0x0000000E, cout 0.
  - 0x00000001 − 0x00000002 → sum 0xFFFFFFFF, cout 1.
  - 0x5 − 0x5 → sum 0, cout 0.
- Carry wrap:
  - 0xFFFFFFFF + 0x00000001 → sum 0x00000000, cout 1.
  - 0x80000000 + 0x80000000 → sum 0x00000000, cout 1.
  - 0xFFFFFFF0 + 0xFFFFFFF0 → sum 0xFFFFFFE0, cout 1.
  - 0x00000010 + 0xFFFFFFF0 → sum 0x00000000, cout 1.
  - 0x00000005 + 0xFFFFFFFF → sum 0x00000004, cout 1.
- Back-to-back and pipelining:
  - Change operands every cycle for 8 cycles with a mixed add/sub sequence; each output must match the operands of the previous cycle exactly.
  - Assert rst in cycle 4 → output 0/0 in the following cycle, then results resume.
- Random: 10,000 random a/b/cin vectors compared one cycle later against a 33-bit reference model (add: {cout,sum}=a+b; sub: sum=a−b, cout=(a<b)).
